// File: rtl/pipelined_variable_right_shift.sv
// rtl/pipelined_variable_right_shift.sv - registered log-shifter: stage k shifts right by 2^k
// when shift bit k is set, with logical/arithmetic fill and a sticky OR of dropped bits.
module pipelined_variable_right_shift #(
  parameter int N = 8,
  parameter int W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arg_vld,
  input  logic [N-1:0] a,
  input  logic [W-1:0] shamt,
  input  logic         arith,
  output logic         res_vld,
  output logic [N-1:0] res,
  output logic         sticky
);

  for (genvar k = 0; k < W; k++) begin : g_stg
    localparam int SH = 1 << k;

    logic [N-1:0]   d_in, d_nx, d_q;
    logic           s_in, s_nx, s_q;
    logic           f_in;
    logic           v_in, v_q;
    // bit 0 is this stage's shift bit; the upper bits are still pending
    logic [W-k-1:0] sh_in;

    if (k == 0) begin : g_src
      assign d_in  = a;
      assign s_in  = 1'b0;
      assign f_in  = arith & a[N-1];
      assign v_in  = arg_vld;
      assign sh_in = shamt;
    end else begin : g_src
      assign d_in  = g_stg[k-1].d_q;
      assign s_in  = g_stg[k-1].s_q;
      assign f_in  = g_stg[k-1].g_fwd.f_q;
      assign v_in  = g_stg[k-1].v_q;
      assign sh_in = g_stg[k-1].g_fwd.sh_q;
    end

    if (SH >= N) begin : g_full
      always_comb begin
        d_nx = d_in;
        s_nx = s_in;
        if (sh_in[0]) begin
          d_nx = {N{f_in}};
          s_nx = s_in | (|d_in);
        end
      end
    end else begin : g_part
      localparam logic [N-1:0] LO_MASK = {N{1'b1}} >> (N - SH);
      always_comb begin
        d_nx = d_in;
        s_nx = s_in;
        if (sh_in[0]) begin
          d_nx = (d_in >> SH) | ({N{f_in}} << (N - SH));
          s_nx = s_in | (|(d_in & LO_MASK));
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
        s_q <= 1'b0;
      end else begin
        v_q <= v_in;
        if (v_in) begin
          d_q <= d_nx;
          s_q <= s_nx;
        end
      end
    end

    // fill and pending shift bits are only needed by later stages
    if (k < W - 1) begin : g_fwd
      logic [W-k-2:0] sh_q;
      logic           f_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          sh_q <= '0;
          f_q  <= 1'b0;
        end else if (v_in) begin
          sh_q <= sh_in[W-k-1:1];
          f_q  <= f_in;
        end
      end
    end
  end

  assign res_vld = g_stg[W-1].v_q;
  assign res     = g_stg[W-1].d_q;
  assign sticky  = g_stg[W-1].s_q;

endmodule

// File: tb/tb_pipelined_variable_right_shift.sv
// tb/tb_pipelined_variable_right_shift.sv - scoreboard bench for pipelined_variable_right_shift
// at N=8 and N=6; expected results are queued at issue and checked by cycle-stamped monitors.
module tb_pipelined_variable_right_shift;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v8, ar8, rv8, s8;
  logic [7:0] a8, r8;
  logic [3:0] sh8;
  logic       v6, ar6, rv6, s6;
  logic [5:0] a6, r6;
  logic [3:0] sh6;

  pipelined_variable_right_shift #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .arg_vld(v8), .a(a8), .shamt(sh8), .arith(ar8),
    .res_vld(rv8), .res(r8), .sticky(s8)
  );

  pipelined_variable_right_shift #(.N(6)) dut6 (
    .clk(clk), .rst(rst), .arg_vld(v6), .a(a6), .shamt(sh6), .arith(ar6),
    .res_vld(rv6), .res(r6), .sticky(s6)
  );

  typedef struct {
    logic [7:0] r;
    logic       s;
    int         due;
  } exp_t;

  exp_t q8[$];
  exp_t q6[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, want, cyc);
  endtask

  // shift one bit at a time, collecting the dropped bit and inserting fill at bit n-1
  function automatic logic [8:0] model(input logic [7:0] a, input int sh, input logic ar, input int n);
    logic [7:0] r;
    logic       s;
    logic       f;
    f = ar & a[n-1];
    r = a;
    s = 1'b0;
    for (int i = 0; i < sh; i++) begin
      s = s | r[0];
      r = r >> 1;
      r[n-1] = f;
    end
    return {s, r};
  endfunction

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rv8) begin
      if (q8.size() == 0) compare("dut8 unexpected res_vld", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        compare("dut8 res", {24'd0, r8}, {24'd0, e.r});
        compare("dut8 sticky", {31'd0, s8}, {31'd0, e.s});
        compare("dut8 latency", cyc, e.due);
      end
    end else if (q8.size() > 0 && q8[0].due <= cyc) begin
      e = q8.pop_front();
      compare("dut8 missing res_vld", 32'd0, 32'd1);
    end
  end

  always @(negedge clk) begin : mon6
    exp_t e;
    if (rv6) begin
      if (q6.size() == 0) compare("dut6 unexpected res_vld", 32'd1, 32'd0);
      else begin
        e = q6.pop_front();
        compare("dut6 res", {26'd0, r6}, {24'd0, e.r});
        compare("dut6 sticky", {31'd0, s6}, {31'd0, e.s});
        compare("dut6 latency", cyc, e.due);
      end
    end else if (q6.size() > 0 && q6[0].due <= cyc) begin
      e = q6.pop_front();
      compare("dut6 missing res_vld", 32'd0, 32'd1);
    end
  end

  // drive one cycle on dut8; expected value queued only when push=1
  task automatic go8(input logic v, input logic push, input logic [7:0] a, input logic [3:0] sh,
                     input logic ar, input logic [7:0] er, input logic es);
    v8 = v; a8 = a; sh8 = sh; ar8 = ar;
    if (v && push) q8.push_back('{r: er, s: es, due: cyc + 4});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] m;
    rst = 1'b1;
    v8 = 1'b0; a8 = '0; sh8 = '0; ar8 = 1'b0;
    v6 = 1'b0; a6 = '0; sh6 = '0; ar6 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    compare("reset res_vld", {31'd0, rv8}, 32'd0);
    compare("reset res", {24'd0, r8}, 32'd0);
    compare("reset sticky", {31'd0, s8}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // directed: logical, arithmetic, boundary amounts
    go8(1, 1, 8'hB6, 4'd3,  1'b0, 8'h16, 1'b1);
    go8(1, 1, 8'hB6, 4'd3,  1'b1, 8'hF6, 1'b1);
    go8(1, 1, 8'h40, 4'd3,  1'b1, 8'h08, 1'b0);
    go8(1, 1, 8'h5A, 4'd0,  1'b0, 8'h5A, 1'b0);
    go8(1, 1, 8'h80, 4'd8,  1'b0, 8'h00, 1'b1);
    go8(1, 1, 8'h80, 4'd15, 1'b1, 8'hFF, 1'b1);
    go8(1, 1, 8'h00, 4'd9,  1'b0, 8'h00, 1'b0);
    go8(1, 1, 8'hFF, 4'd7,  1'b1, 8'hFF, 1'b1);
    go8(1, 1, 8'h7F, 4'd7,  1'b1, 8'h00, 1'b1);
    go8(0, 0, 8'h00, 4'd0,  1'b0, 8'h00, 1'b0);

    // streaming with a bubble
    go8(1, 1, 8'h01, 4'd1, 1'b0, 8'h00, 1'b1);
    go8(1, 1, 8'h02, 4'd1, 1'b0, 8'h01, 1'b0);
    go8(0, 0, 8'hAA, 4'd1, 1'b0, 8'h00, 1'b0);
    go8(1, 1, 8'h04, 4'd1, 1'b0, 8'h02, 1'b0);
    go8(1, 1, 8'h08, 4'd1, 1'b0, 8'h04, 1'b0);
    repeat (6) go8(0, 0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0);

    // reset mid-flight: none of these three may ever emerge
    go8(1, 0, 8'hF0, 4'd2, 1'b0, 8'h00, 1'b0);
    go8(1, 0, 8'h0F, 4'd1, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    go8(1, 0, 8'h33, 4'd0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    v8 = 1'b1; a8 = 8'h81; sh8 = 4'd1; ar8 = 1'b0;
    q8.push_back('{r: 8'h40, s: 1'b1, due: cyc + 4});
    @(negedge clk);
    compare("post-reset res_vld", {31'd0, rv8}, 32'd0);
    compare("post-reset res", {24'd0, r8}, 32'd0);
    compare("post-reset sticky", {31'd0, s8}, 32'd0);
    @(posedge clk);
    #1;
    v8 = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // random traffic on both widths against the bit-serial model
    for (int i = 0; i < 400; i++) begin
      v8 = 1'($urandom_range(0, 1)); a8 = 8'($urandom); sh8 = 4'($urandom_range(0, 15)); ar8 = 1'($urandom);
      v6 = 1'($urandom_range(0, 1)); a6 = 6'($urandom); sh6 = 4'($urandom_range(0, 15)); ar6 = 1'($urandom);
      if (v8) begin
        m = model(a8, int'(sh8), ar8, 8);
        q8.push_back('{r: m[7:0], s: m[8], due: cyc + 4});
      end
      if (v6) begin
        m = model({2'b00, a6}, int'(sh6), ar6, 6);
        q6.push_back('{r: m[7:0], s: m[8], due: cyc + 4});
      end
      @(posedge clk);
      #1;
    end
    v8 = 1'b0;
    v6 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    compare("dut8 scoreboard drained", q8.size(), 32'd0);
    compare("dut6 scoreboard drained", q6.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
